// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS datapath with a valid/ready memory handshake, stall FSM and wait timeout.
// Define MC_DP_BNE_EN to add the pc_write_cond_ne port (branch on not-equal).
module mc_datapath_hs #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iord,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic            ir_write,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic            alu_src_a,
  input  logic            pc_write,
  input  logic            pc_write_cond,
`ifdef MC_DP_BNE_EN
  input  logic            pc_write_cond_ne,
`endif
  input  logic [1:0]      reg_dst,
  input  logic [1:0]      alu_src_b,
  input  logic [2:0]      alu_ctrl,
  input  logic [1:0]      pc_src,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            mem_err,
  output logic            zero,
  output logic [31:0]     inst
);

  localparam int unsigned    RW       = $clog2(NREG);
  localparam int unsigned    CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [RW-1:0]  LINK_IDX = RW'(NREG - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_valid, w_err, w_busy, w_en;

  logic [XLEN-1:0] r_pc, r_mdr, r_a, r_b, r_aluout;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rf [NREG];

  logic [RW-1:0]   w_rs, w_rt, w_rd, w_wr_idx;
  logic [XLEN-1:0] w_rs_val, w_rt_val, w_wr_data, w_imm_ext;
  logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res, w_jump, w_pc_nxt;
  logic            w_pc_ld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_valid = mem_rd | mem_wr;
        if (w_valid && !mem_ready) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        w_valid = 1'b1;
        if (mem_ready)
          w_state_nxt = ST_IDLE;
        else if ((TIMEOUT != 0) && (r_cnt == TO_LAST))
          w_state_nxt = ST_ERR;
        else
          w_cnt_nxt = r_cnt + 1'b1;
      end
      ST_ERR: begin
        w_err       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy = (w_valid & ~mem_ready) | w_err;
  assign w_en   = ~w_busy;

  // Reset only masks the handshake outputs; internal enables never see it as data.
  assign mem_valid = w_valid & rst;
  assign busy      = w_busy & rst;
  assign mem_err   = w_err;
  assign mem_we    = mem_wr & mem_valid;

  assign w_rs     = r_ir[21 +: RW];
  assign w_rt     = r_ir[16 +: RW];
  assign w_rd     = r_ir[11 +: RW];
  assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];

  assign w_imm_ext = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
  assign w_alu_a   = alu_src_a ? r_a : r_pc;

  always_comb begin
    w_alu_b = r_b;
    case (alu_src_b)
      2'd0: w_alu_b = r_b;
      2'd1: w_alu_b = XLEN'(32'd4);
      2'd2: w_alu_b = w_imm_ext;
      2'd3: w_alu_b = w_imm_ext << 2;
      default: w_alu_b = r_b;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (alu_ctrl)
      3'b000: w_alu_res = w_alu_a & w_alu_b;
      3'b001: w_alu_res = w_alu_a | w_alu_b;
      3'b010: w_alu_res = w_alu_a + w_alu_b;
      3'b110: w_alu_res = w_alu_a - w_alu_b;
      3'b111: w_alu_res = XLEN'($signed(w_alu_a) < $signed(w_alu_b));
      default: w_alu_res = '0;
    endcase
  end

  assign zero   = (w_alu_res == '0);
  assign w_jump = {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};

  always_comb begin
    w_pc_nxt = w_alu_res;
    case (pc_src)
      2'd0: w_pc_nxt = w_alu_res;
      2'd1: w_pc_nxt = w_jump;
      2'd2: w_pc_nxt = r_aluout;
      2'd3: w_pc_nxt = r_a;
      default: w_pc_nxt = w_alu_res;
    endcase
  end

`ifdef MC_DP_BNE_EN
  assign w_pc_ld = pc_write | (pc_write_cond & zero) | (pc_write_cond_ne & ~zero);
`else
  assign w_pc_ld = pc_write | (pc_write_cond & zero);
`endif

  always_comb begin
    w_wr_idx = w_rt;
    case (reg_dst)
      2'd1: w_wr_idx = w_rd;
      2'd2: w_wr_idx = LINK_IDX;
      default: w_wr_idx = w_rt;
    endcase
  end

  assign w_wr_data = mem_to_reg ? r_mdr : r_aluout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_en) begin
      r_mdr    <= mem_rdata;
      r_a      <= w_rs_val;
      r_b      <= w_rt_val;
      r_aluout <= w_alu_res;
      if (ir_write) r_ir <= mem_rdata[31:0];
      if (w_pc_ld) r_pc <= w_pc_nxt;
      if (reg_write && (w_wr_idx != '0)) r_rf[w_wr_idx] <= w_wr_data;
    end
  end

  assign mem_addr  = iord ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign inst      = r_ir;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Self-checking bench for mc_datapath_hs (XLEN=64, NREG=16, RESET_PC=0x100, TIMEOUT=4).
module tb_mc_datapath_hs;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b110, OP_SLT = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        iord, mem_rd, mem_wr, ir_write, reg_write, mem_to_reg;
  logic        alu_src_a, pc_write, pc_write_cond;
`ifdef MC_DP_BNE_EN
  logic        pc_write_cond_ne;
`endif
  logic [1:0]  reg_dst, alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic        mem_valid, mem_we, mem_ready, busy, mem_err, zero;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] inst;

  mc_datapath_hs #(.XLEN(64), .NREG(16), .RESET_PC(64'h100), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
`ifdef MC_DP_BNE_EN
    .pc_write_cond_ne(pc_write_cond_ne),
`endif
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .mem_err(mem_err),
    .zero(zero), .inst(inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] imm;
    logic [1:0]  srcb;
    logic [2:0]  ctrl;
    logic [63:0] res;
    logic        z;
  } vec_t;

  vec_t        vecs [14];
  logic [63:0] sbq [$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [63:0] act);
    logic [63:0] e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h expected <empty scoreboard>", name, act);
    end else begin
      e = sbq.pop_front();
      chk(name, act, e);
    end
  endtask

  task automatic idle_ctrl();
    iord = 0; mem_rd = 0; mem_wr = 0; ir_write = 0; reg_write = 0; mem_to_reg = 0;
    alu_src_a = 0; pc_write = 0; pc_write_cond = 0; reg_dst = 0; alu_src_b = 0;
    alu_ctrl = 0; pc_src = 0; mem_ready = 0;
`ifdef MC_DP_BNE_EN
    pc_write_cond_ne = 0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] w);
    idle_ctrl();
    mem_rd = 1; mem_ready = 1; ir_write = 1; mem_rdata = {32'h0, w};
    cyc();
    idle_ctrl();
  endtask

  // IR rt <- idx, MDR <- val, then rf[rt] <- MDR
  task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
    set_ir({6'b0, 5'd0, idx, 16'h0});
    mem_rd = 1; mem_ready = 1; mem_rdata = val;
    cyc();
    idle_ctrl();
    reg_write = 1; mem_to_reg = 1; reg_dst = 2'd0;
    cyc();
    idle_ctrl();
  endtask

  task automatic branch_case(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic ceq, input logic cne, input logic ez);
    write_reg(5'd1, a);
    write_reg(5'd2, b);
    set_ir({6'b0, 5'd1, 5'd2, 16'h0010});
    cyc();
    alu_src_a = 0; alu_src_b = 2'd3; alu_ctrl = OP_ADD;
    cyc();
    idle_ctrl();
    alu_src_a = 1; alu_src_b = 2'd0; alu_ctrl = OP_SUB; pc_src = 2'd2; pc_write_cond = ceq;
`ifdef MC_DP_BNE_EN
    pc_write_cond_ne = cne;
`endif
    if ((ceq && ez) || (cne && !ez)) exp_pc = exp_pc + 64'h40;
    sbq.push_back(exp_pc);
    @(negedge clk);
    chk({name, "_zero"}, zero, ez);
    cyc();
    idle_ctrl();
    @(negedge clk);
    sb_check({name, "_pc"}, mem_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nbusy, nvalid, nerr;
    logic        seen;
    logic [31:0] w1, w2;
    logic [63:0] k;

    w1 = {6'b0, 5'd3, 5'd4, 16'h1234};
    w2 = {6'b0, 5'd0, 5'd15, 16'h0055};
    k  = 64'h0123_4567_89AB_CDEF;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16'h0001, 2'd2, OP_ADD, 64'h0, 1'b1};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 16'h0, 2'd0, OP_SLT, 64'h1, 1'b0};
    vecs[2]  = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0, 2'd0, OP_SLT, 64'h0, 1'b1};
    vecs[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 16'h0, 2'd0, OP_SLT, 64'h0, 1'b1};
    vecs[4]  = '{64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_1234_00FF, 16'h0, 2'd0, OP_AND,
                 64'hF000_F000_0000_00FF, 1'b0};
    vecs[5]  = '{64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_1234_00FF, 16'h0, 2'd0, OP_OR,
                 64'hFFF0_FFF0_1234_FFFF, 1'b0};
    vecs[6]  = '{64'h5, 64'h7, 16'h0, 2'd0, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[7]  = '{64'h100, 64'h0, 16'hFFFE, 2'd3, OP_ADD, 64'hF8, 1'b0};
    vecs[8]  = '{64'h10, 64'h0, 16'h0, 2'd1, OP_ADD, 64'h14, 1'b0};
    vecs[9]  = '{64'h0, 64'h0, 16'h7FFF, 2'd2, OP_ADD, 64'h7FFF, 1'b0};
    vecs[10] = '{64'h5, 64'h7, 16'h0, 2'd0, 3'b011, 64'h0, 1'b1};
    vecs[11] = '{64'h5, 64'h7, 16'h0, 2'd0, 3'b100, 64'h0, 1'b1};
    vecs[12] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 16'h0, 2'd0, OP_SUB, 64'h0, 1'b1};
    vecs[13] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 16'h0, 2'd0, OP_ADD, 64'h0, 1'b1};

    // Reset state with a pending fetch request
    rst = 0;
    idle_ctrl();
    mem_rdata = '0;
    mem_rd = 1; mem_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_pc", mem_addr, 64'h100);
    chk("rst_ir", inst, 0);
    chk("rst_b", mem_wdata, 0);
    rst = 1;

    // Zero-wait fetch
    ir_write = 1; pc_write = 1; alu_src_b = 2'd1; alu_ctrl = OP_ADD; pc_src = 2'd0;
    mem_rdata = {32'hAAAA_5555, w1};
    #1;
    chk("fetch_valid", mem_valid, 1);
    chk("fetch_busy", busy, 0);
    chk("fetch_we", mem_we, 0);
    chk("fetch_addr", mem_addr, 64'h100);
    cyc();
    idle_ctrl();
    @(negedge clk);
    chk("fetch_ir", inst, w1);
    chk("fetch_pc", mem_addr, 64'h104);
    exp_pc = 64'h104;

    // Fetch with ready delayed 3 cycles
    idle_ctrl();
    mem_rd = 1; ir_write = 1; pc_write = 1; alu_src_b = 2'd1; alu_ctrl = OP_ADD;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    nbusy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      chk($sformatf("wait_addr[%0d]", i), mem_addr, 64'h104);
      chk($sformatf("wait_ir[%0d]", i), inst, w1);
      cyc();
    end
    mem_ready = 1; mem_rdata = {32'hCAFE_F00D, w2};
    @(negedge clk);
    if (busy) nbusy++;
    chk("wait_done_valid", mem_valid, 1);
    chk("wait_busy_cycles", nbusy, 3);
    cyc();
    idle_ctrl();
    @(negedge clk);
    chk("wait_ir_loaded", inst, w2);
    chk("wait_pc", mem_addr, 64'h108);
    exp_pc = 64'h108;
    reg_write = 1; mem_to_reg = 1; reg_dst = 2'd2; mem_rdata = 64'h1111_2222_3333_4444;
    cyc();
    idle_ctrl();
    cyc();
    @(negedge clk);
    chk("wait_mdr", mem_wdata, {32'hCAFE_F00D, w2});

    // ALUOUT = 0 + 0x55, then link write into register 15
    alu_src_a = 1; alu_src_b = 2'd2; alu_ctrl = OP_ADD;
    sbq.push_back(64'h55);
    @(negedge clk);
    chk("link_zero", zero, 0);
    cyc();
    idle_ctrl();
    iord = 1;
    @(negedge clk);
    sb_check("link_aluout", mem_addr);
    reg_write = 1; reg_dst = 2'd2; mem_to_reg = 0;
    cyc();
    idle_ctrl();
    cyc();
    @(negedge clk);
    chk("link_r15", mem_wdata, 64'h55);
    mem_wr = 1; mem_ready = 1;
    @(negedge clk);
    chk("write_we", mem_we, 1);
    chk("write_valid", mem_valid, 1);
    chk("write_busy", busy, 0);
    cyc();
    idle_ctrl();

    // Timeout: MDR holds K across the aborted read
    mem_rd = 1; mem_ready = 1; mem_rdata = k;
    cyc();
    idle_ctrl();
    mem_rd = 1; ir_write = 1; mem_rdata = 64'h0BAD_0BAD_FFFF_FFFF;
    nvalid = 0; nerr = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) nvalid++;
      if (mem_err) begin
        nerr++;
        seen = 1;
        chk("err_busy", busy, 1);
      end
      cyc();
    end
    chk("to_valid_cycles", nvalid, 5);
    idle_ctrl();
    reg_write = 1; mem_to_reg = 1; reg_dst = 2'd2;
    @(negedge clk);
    if (mem_err) nerr++;
    chk("to_err_pulse", nerr, 1);
    chk("to_idle_valid", mem_valid, 0);
    chk("to_idle_busy", busy, 0);
    cyc();
    idle_ctrl();
    cyc();
    @(negedge clk);
    chk("to_mdr_kept", mem_wdata, k);
    chk("to_ir_kept", inst, w2);

    // Register 0 ignores writes
    write_reg(5'd0, 64'hDEAD_BEEF_0000_1234);
    cyc();
    @(negedge clk);
    chk("r0_zero", mem_wdata, 64'h0);

    // ALU vectors: A=r1, B=r2, result observed through ALUOUT
    for (int i = 0; i < 14; i++) begin
      write_reg(5'd1, vecs[i].a);
      write_reg(5'd2, vecs[i].b);
      set_ir({6'b0, 5'd1, 5'd2, vecs[i].imm});
      cyc();
      alu_src_a = 1; alu_src_b = vecs[i].srcb; alu_ctrl = vecs[i].ctrl;
      sbq.push_back(vecs[i].res);
      @(negedge clk);
      chk($sformatf("alu[%0d]_zero", i), zero, vecs[i].z);
      chk($sformatf("alu[%0d]_b", i), mem_wdata, vecs[i].b);
      cyc();
      idle_ctrl();
      iord = 1;
      @(negedge clk);
      sb_check($sformatf("alu[%0d]_res", i), mem_addr);
    end

    // Conditional branches to ALUOUT = PC + 0x40
    branch_case("beq_nt", 64'd5, 64'd7, 1'b1, 1'b0, 1'b0);
    branch_case("beq_t", 64'd9, 64'd9, 1'b1, 1'b0, 1'b1);
`ifdef MC_DP_BNE_EN
    branch_case("bne_t", 64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
    branch_case("bne_nt", 64'd9, 64'd9, 1'b0, 1'b1, 1'b1);
`endif

    // Jump, register jump, then jump keeping PC upper bits
    set_ir({6'b0, 26'h3ABCDE});
    pc_write = 1; pc_src = 2'd1;
    cyc();
    idle_ctrl();
    @(negedge clk);
    chk("jump_pc", mem_addr, 64'hEAF378);
    write_reg(5'd1, 64'h1234_5678_9ABC_DEF0);
    set_ir({6'b0, 5'd1, 5'd0, 16'h0});
    cyc();
    pc_write = 1; pc_src = 2'd3;
    cyc();
    idle_ctrl();
    @(negedge clk);
    chk("jr_pc", mem_addr, 64'h1234_5678_9ABC_DEF0);
    set_ir({6'b0, 26'h0000001});
    pc_write = 1; pc_src = 2'd1;
    cyc();
    idle_ctrl();
    @(negedge clk);
    chk("jump_hi_pc", mem_addr, 64'h1234_5678_9000_0004);

    // Reset asserted mid-transfer
    cyc();
    mem_rd = 1; mem_ready = 0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    #1 rst = 0;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", mem_addr, 64'h100);
    chk("mid_rst_ir", inst, 0);
    idle_ctrl();
    @(negedge clk);
    rst = 1;
    cyc();
    @(negedge clk);
    chk("post_rst_valid", mem_valid, 0);
    chk("post_rst_err", mem_err, 0);
    chk("post_rst_b", mem_wdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
